// File: rtl/uart_tx_feeder_if.sv
// uart_tx_feeder_if: host write port and transmitter handshake for uart_tx_feeder.
// The master side is the host/transmitter environment; the slave side is the feeder.
interface uart_tx_feeder_if #(
    parameter int AW = 3
);
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full;
    logic          empty;
    logic [AW:0]   level;
    logic [7:0]    tx_data;
    logic          tx_rdy;
    logic          tx_busy;
    logic          tx_done;
    logic          tx_error;
    logic [7:0]    sent_cnt;
    logic          timeout_err;
    logic          drop_err;

    modport master (
        output wr_en, wr_data, tx_busy, tx_done, tx_error,
        input  full, empty, level, tx_data, tx_rdy, sent_cnt, timeout_err, drop_err
    );

    modport slave (
        input  wr_en, wr_data, tx_busy, tx_done, tx_error,
        output full, empty, level, tx_data, tx_rdy, sent_cnt, timeout_err, drop_err
    );
endinterface

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO in front of the UART transmit FSM. Pops one byte at a
// time, presents it with tx_rdy, counts completed bytes and flags a stalled
// transmitter through a watchdog.
// Optional macro UART_TX_RETRY_EN: tx_error during WAIT_DONE resends the byte up
// to three times, then drops it and sets drop_err. Without it tx_error is ignored
// and drop_err is tied low.
module uart_tx_feeder #(
    parameter int DEPTH   = 8,
    parameter int AW      = 3,
    parameter int TIMEOUT = 255
) (
    input  logic             clka,
    input  logic             reset,
    uart_tx_feeder_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT_DONE
    } state_t;

    localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LEVEL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [15:0]   WD_LAST    = 16'(TIMEOUT - 1);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level_q;
    logic          full_w;
    logic          empty_w;
    logic          push;
    logic          pop;

    state_t        state_q;
    state_t        state_n;
    logic [7:0]    tx_data_q;
    logic [7:0]    tx_data_n;
    logic          tx_rdy_q;
    logic          tx_rdy_n;
    logic [7:0]    sent_cnt_q;
    logic [7:0]    sent_cnt_n;
    logic [15:0]   wd_q;
    logic [15:0]   wd_n;
    logic          timeout_err_q;
    logic          timeout_err_n;

`ifdef UART_TX_RETRY_EN
    logic [1:0]    retry_q;
    logic [1:0]    retry_n;
    logic          drop_err_q;
    logic          drop_err_n;
`endif

    assign full_w  = (level_q == FULL_LEVEL);
    assign empty_w = (level_q == '0);
    assign push    = bus.wr_en && !full_w;
    assign pop     = (state_q == LOAD);

    // FIFO pointers and occupancy; a write is judged on the pre-edge full flag
    always_ff @(posedge clka) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                level_q <= level_q + LEVEL_ONE;
            end else if (!push && pop) begin
                level_q <= level_q - LEVEL_ONE;
            end
        end
    end

    // FIFO storage needs no reset since occupancy guards every read
    always_ff @(posedge clka) begin
        if (push) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    // Next-state and next-output logic of the transmit handshake FSM
    always_comb begin
        state_n       = state_q;
        tx_data_n     = tx_data_q;
        tx_rdy_n      = tx_rdy_q;
        sent_cnt_n    = sent_cnt_q;
        wd_n          = wd_q;
        timeout_err_n = timeout_err_q;
`ifdef UART_TX_RETRY_EN
        retry_n       = retry_q;
        drop_err_n    = drop_err_q;
`endif
        case (state_q)
            IDLE: begin
                tx_rdy_n = 1'b0;
                if (!empty_w) begin
                    state_n = LOAD;
                end
            end
            LOAD: begin
                tx_data_n = mem[rd_ptr];
                wd_n      = '0;
`ifdef UART_TX_RETRY_EN
                retry_n   = '0;
`endif
                tx_rdy_n  = 1'b1;
                state_n   = SEND;
            end
            SEND: begin
                if (bus.tx_done) begin
                    tx_rdy_n   = 1'b0;
                    sent_cnt_n = sent_cnt_q + 8'd1;
                    state_n    = empty_w ? IDLE : LOAD;
                end else if (bus.tx_busy) begin
                    tx_rdy_n = 1'b0;
                    wd_n     = wd_q + 16'd1;
                    state_n  = WAIT_DONE;
                end else if (wd_q >= WD_LAST) begin
                    timeout_err_n = 1'b1;
                    tx_rdy_n      = 1'b0;
                    state_n       = IDLE;
                end else begin
                    wd_n = wd_q + 16'd1;
                end
            end
            WAIT_DONE: begin
                tx_rdy_n = 1'b0;
                if (bus.tx_done) begin
                    sent_cnt_n = sent_cnt_q + 8'd1;
                    state_n    = empty_w ? IDLE : LOAD;
`ifdef UART_TX_RETRY_EN
                end else if (bus.tx_error) begin
                    if (retry_q == 2'd3) begin
                        drop_err_n = 1'b1;
                        state_n    = IDLE;
                    end else begin
                        retry_n  = retry_q + 2'd1;
                        wd_n     = '0;
                        tx_rdy_n = 1'b1;
                        state_n  = SEND;
                    end
`endif
                end else if (wd_q >= WD_LAST) begin
                    timeout_err_n = 1'b1;
                    state_n       = IDLE;
                end else begin
                    wd_n = wd_q + 16'd1;
                end
            end
            default: begin
                tx_rdy_n = 1'b0;
                state_n  = IDLE;
            end
        endcase
    end

    // FSM state and registered outputs; reset drops any in-flight byte
    always_ff @(posedge clka) begin
        if (!reset) begin
            state_q       <= IDLE;
            tx_data_q     <= 8'h00;
            tx_rdy_q      <= 1'b0;
            sent_cnt_q    <= 8'd0;
            wd_q          <= '0;
            timeout_err_q <= 1'b0;
`ifdef UART_TX_RETRY_EN
            retry_q       <= '0;
            drop_err_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_n;
            tx_data_q     <= tx_data_n;
            tx_rdy_q      <= tx_rdy_n;
            sent_cnt_q    <= sent_cnt_n;
            wd_q          <= wd_n;
            timeout_err_q <= timeout_err_n;
`ifdef UART_TX_RETRY_EN
            retry_q       <= retry_n;
            drop_err_q    <= drop_err_n;
`endif
        end
    end

`ifdef UART_TX_RETRY_EN
    assign bus.drop_err = drop_err_q;
`else
    logic unused_tx_error;
    assign unused_tx_error = bus.tx_error;
    assign bus.drop_err    = 1'b0;
`endif

    assign bus.full        = full_w;
    assign bus.empty       = empty_w;
    assign bus.level       = level_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_rdy      = tx_rdy_q;
    assign bus.sent_cnt    = sent_cnt_q;
    assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: directed bench for uart_tx_feeder acting as host and as a
// simple transmitter model driven step by step.
module tb_uart_tx_feeder;

    localparam int RDY_BUDGET = 20;
`ifdef UART_TX_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    logic clka;
    logic reset;
    int   checks_total;
    int   checks_passed;
    int   checks_failed;

    uart_tx_feeder_if #(.AW(3)) bus ();

    uart_tx_feeder #(
        .DEPTH   (8),
        .AW      (3),
        .TIMEOUT (255)
    ) dut (
        .clka  (clka),
        .reset (reset),
        .bus   (bus)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    // Drive one cycle of host/transmitter inputs and step past the edge
    task automatic applyStimulus(input logic we, input logic [7:0] wd,
                                 input logic busy, input logic done, input logic err);
        bus.wr_en    = we;
        bus.wr_data  = wd;
        bus.tx_busy  = busy;
        bus.tx_done  = done;
        bus.tx_error = err;
        @(posedge clka);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks_total++;
        assert (observed === expected) begin
            checks_passed++;
        end else begin
            checks_failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic waitForRdy(input string tag);
        int n;
        n = 0;
        while (bus.tx_rdy !== 1'b1 && n < RDY_BUDGET) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            n++;
        end
        checkOutput(tag, 32'(bus.tx_rdy), 32'd1);
    endtask

    task automatic doReset();
        reset = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
    endtask

    // Global bound so a hung handshake still ends the run
    initial begin
        #100000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        checks_failed = 0;
        reset         = 1'b0;
        bus.wr_en     = 1'b0;
        bus.wr_data   = 8'h00;
        bus.tx_busy   = 1'b0;
        bus.tx_done   = 1'b0;
        bus.tx_error  = 1'b0;

        // Reset state
        doReset();
        checkOutput("rst_level",    32'(bus.level),       32'd0);
        checkOutput("rst_empty",    32'(bus.empty),       32'd1);
        checkOutput("rst_full",     32'(bus.full),        32'd0);
        checkOutput("rst_tx_rdy",   32'(bus.tx_rdy),      32'd0);
        checkOutput("rst_tx_data",  32'(bus.tx_data),     32'h00);
        checkOutput("rst_sent_cnt", 32'(bus.sent_cnt),    32'd0);
        checkOutput("rst_timeout",  32'(bus.timeout_err), 32'd0);
        checkOutput("rst_drop",     32'(bus.drop_err),    32'd0);

        // Single byte A5: tx_rdy three cycles after the write cycle
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        checkOutput("a5_level1",  32'(bus.level),  32'd1);
        checkOutput("a5_rdy_c1",  32'(bus.tx_rdy), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("a5_rdy_c2",  32'(bus.tx_rdy), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("a5_rdy_c3",  32'(bus.tx_rdy),  32'd1);
        checkOutput("a5_data",    32'(bus.tx_data), 32'hA5);
        checkOutput("a5_popped",  32'(bus.empty),   32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("a5_hold",    32'(bus.tx_data), 32'hA5);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("a5_rdy_drop", 32'(bus.tx_rdy), 32'd0);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        checkOutput("a5_not_yet", 32'(bus.sent_cnt), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        checkOutput("a5_sent",  32'(bus.sent_cnt), 32'd1);
        checkOutput("a5_empty", 32'(bus.empty),    32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("a5_idle",  32'(bus.tx_rdy),   32'd0);

        // Fill the FIFO behind a stalled byte, then drain it in order
        doReset();
        applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        waitForRdy("fill_primer_rdy");
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b1, 8'(k), 1'b0, 1'b0, 1'b0);
        end
        checkOutput("fill_level8", 32'(bus.level), 32'd8);
        checkOutput("fill_full",   32'(bus.full),  32'd1);
        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        checkOutput("fill_9th_ignored", 32'(bus.level), 32'd8);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        checkOutput("fill_primer_sent", 32'(bus.sent_cnt), 32'd1);
        // Write while full in the same cycle as the LOAD pop
        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        checkOutput("pop_wr_level7", 32'(bus.level),   32'd7);
        checkOutput("pop_wr_nfull",  32'(bus.full),    32'd0);
        checkOutput("pop_wr_data",   32'(bus.tx_data), 32'h01);
        for (int k = 1; k <= 8; k++) begin
            waitForRdy($sformatf("drain_rdy_%0d", k));
            checkOutput($sformatf("drain_data_%0d", k), 32'(bus.tx_data), 32'(k));
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        end
        checkOutput("drain_sent",  32'(bus.sent_cnt), 32'd9);
        checkOutput("drain_level", 32'(bus.level),    32'd0);
        checkOutput("drain_empty", 32'(bus.empty),    32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("drain_no_ff", 32'(bus.tx_rdy), 32'd0);

        // Transmitter never answers: watchdog fires 255 cycles after tx_rdy rises
        doReset();
        applyStimulus(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("wd_rdy_rise", 32'(bus.tx_rdy), 32'd1);
        for (int i = 0; i < 254; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        end
        checkOutput("wd_rdy_254",  32'(bus.tx_rdy),      32'd1);
        checkOutput("wd_err_254",  32'(bus.timeout_err), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("wd_err_255",  32'(bus.timeout_err), 32'd1);
        checkOutput("wd_rdy_255",  32'(bus.tx_rdy),      32'd0);
        checkOutput("wd_sent",     32'(bus.sent_cnt),    32'd0);
        applyStimulus(1'b1, 8'h88, 1'b0, 1'b0, 1'b0);
        waitForRdy("wd_next_rdy");
        checkOutput("wd_next_data", 32'(bus.tx_data), 32'h88);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        checkOutput("wd_next_sent",   32'(bus.sent_cnt),    32'd1);
        checkOutput("wd_err_sticky",  32'(bus.timeout_err), 32'd1);

        // Reset asserted during WAIT_DONE with three bytes queued
        applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        waitForRdy("mid_rdy");
        applyStimulus(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("mid_level3", 32'(bus.level), 32'd3);
        reset = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        checkOutput("mid_rst_level",   32'(bus.level),       32'd0);
        checkOutput("mid_rst_rdy",     32'(bus.tx_rdy),      32'd0);
        checkOutput("mid_rst_sent",    32'(bus.sent_cnt),    32'd0);
        checkOutput("mid_rst_data",    32'(bus.tx_data),     32'h00);
        checkOutput("mid_rst_timeout", 32'(bus.timeout_err), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("mid_rst_lost",    32'(bus.tx_rdy),      32'd0);

        // Four tx_error pulses on byte 3C, then a tx_done pulse
        doReset();
        applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        waitForRdy("err_rdy");
        checkOutput("err_data", 32'(bus.tx_data), 32'h3C);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            checkOutput($sformatf("err_rdy_%0d", i), 32'(bus.tx_rdy),
                        32'(RETRY_EN && (i < 3)));
            checkOutput($sformatf("err_data_%0d", i), 32'(bus.tx_data), 32'h3C);
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        checkOutput("err_drop", 32'(bus.drop_err), 32'(RETRY_EN));
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        checkOutput("err_sent", 32'(bus.sent_cnt), RETRY_EN ? 32'd0 : 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("err_idle", 32'(bus.tx_rdy),   32'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
